// File: rtl/mux_fn_gen.sv
// mux_fn_gen: programmable multi-function logic generator.
//
// Each of NUM_FN functions of (SEL_W+1) variables is a 2^SEL_W:1 mux. The
// select lines carry the upper variables. Every data leg is a 2-bit code
// that picks 0, 1, D or ~D, where D is the residue variable.
//
// The leg codes sit in two banks. Config writes go to the shadow bank. A
// commit drains the evaluation pipeline and then copies the whole shadow
// bank into the active bank on a single edge, so no result ever mixes the
// two banks.
//
// Ports:
//   clk, rst              clock; asynchronous active-high reset
//   in_valid/in_ready     evaluation request handshake
//   in_sel, in_d          select variables (MSB = A) and residue variable D
//   cfg_valid/cfg_ready   config command handshake
//   cfg_op                0 = write shadow leg, 1 = commit shadow to active
//   cfg_fn, cfg_idx       target function and leg of a write
//   cfg_code              leg code: 00 -> 0, 01 -> 1, 10 -> D, 11 -> ~D
//   cfg_err               one-cycle pulse after an ignored out-of-range write
//   out_valid, fn_out     result strobe (latency 2); bit k = function k

// One function: shadow and active leg banks plus the stage-2 result bit.
module mux_fn_lane #(
    parameter int SEL_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [SEL_W-1:0] wr_idx,
    input  logic [1:0]       wr_code,
    input  logic             swap,
    input  logic             cap,
    input  logic [SEL_W-1:0] s1_sel,
    input  logic             s1_d,
    output logic             fn_bit
);
    localparam int LEGS = 1 << SEL_W;

    logic [LEGS-1:0][1:0] shadow;
    logic [LEGS-1:0][1:0] active;
    logic [1:0]           code;
    logic                 leg;

    assign code = active[s1_sel];
    // code[1] selects D-based legs; code[0] is then the inversion flag.
    assign leg  = code[1] ? (s1_d ^ code[0]) : code[0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow <= '0;
            active <= '0;
            fn_bit <= 1'b0;
        end else begin
            if (wr_en) shadow[wr_idx] <= wr_code;
            if (swap)  active <= shadow;
            if (cap)   fn_bit <= leg;
        end
    end
endmodule

module mux_fn_gen #(
    parameter int SEL_W  = 3,
    parameter int NUM_FN = 2,
    parameter int FN_W   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [SEL_W-1:0]  in_sel,
    input  logic              in_d,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic              cfg_op,
    input  logic [FN_W-1:0]   cfg_fn,
    input  logic [SEL_W-1:0]  cfg_idx,
    input  logic [1:0]        cfg_code,
    output logic              cfg_err,
    output logic              out_valid,
    output logic [NUM_FN-1:0] fn_out
);
    localparam int STAGES = 2;

    typedef enum logic [1:0] {IDLE, DRAIN, SWAP} state_t;

    state_t              state, state_nx;
    logic [STAGES:1]     vld_pipe;   // [1] = stage-1 valid, [STAGES] = out_valid
    logic [SEL_W-1:0]    s1_sel;
    logic                s1_d;
    logic                in_acc;
    logic                wr_acc;
    logic                fn_oor;
    logic [NUM_FN-1:0]   wr_en;

    assign in_acc    = in_valid & in_ready;
    assign wr_acc    = cfg_valid & cfg_ready & ~cfg_op;
    assign fn_oor    = {{(32-FN_W){1'b0}}, cfg_fn} >= NUM_FN;
    assign out_valid = vld_pipe[STAGES];

    // The FSM register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Next state and handshake outputs. Requests and config commands are
    // only taken in IDLE, so nothing new enters while a commit is in flight.
    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        cfg_ready = 1'b0;
        case (state)
            IDLE: begin
                in_ready  = 1'b1;
                cfg_ready = 1'b1;
                if (cfg_valid && cfg_op) state_nx = DRAIN;
            end
            // Wait until stage 1 is empty. A request still in stage 1 is
            // captured by stage 2 against the old active bank on this edge.
            DRAIN:   if (!vld_pipe[1]) state_nx = SWAP;
            SWAP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Stage 1 captures the request. The valid shift register also carries
    // the one-cycle out_valid strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_pipe <= '0;
            s1_sel   <= '0;
            s1_d     <= 1'b0;
            cfg_err  <= 1'b0;
        end else begin
            vld_pipe <= {vld_pipe[STAGES-1:1], in_acc};
            cfg_err  <= wr_acc & fn_oor;
            if (in_acc) begin
                s1_sel <= in_sel;
                s1_d   <= in_d;
            end
        end
    end

    for (genvar k = 0; k < NUM_FN; k++) begin : g_fn
        // An out-of-range index never matches any lane, so it writes nothing.
        assign wr_en[k] = wr_acc && (cfg_fn == FN_W'(k));

        mux_fn_lane #(.SEL_W(SEL_W)) u_lane (
            .clk     (clk),
            .rst     (rst),
            .wr_en   (wr_en[k]),
            .wr_idx  (cfg_idx),
            .wr_code (cfg_code),
            .swap    (state == SWAP),
            .cap     (vld_pipe[1]),
            .s1_sel  (s1_sel),
            .s1_d    (s1_d),
            .fn_bit  (fn_out[k])
        );
    end
endmodule
